// File: rtl/as_pack.sv
// rtl/as_pack.sv - CGU register map, channel identifiers and divider-channel states
package as_pack;

    localparam logic [3:0] CGU_CTRL = 4'h0;
    localparam logic [3:0] CGU_STAT = 4'h1;
    localparam logic [3:0] CGU_DIV0 = 4'h2;

    typedef enum logic [1:0] {CH_BUS1, CH_BUS2, CH_QSPI, CH_CORE} cgu_ch_e;

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_PEND} ch_state_e;

endpackage

// File: rtl/as_cgu_divchan.sv
// rtl/as_cgu_divchan.sv - one enable channel: period counter, staged divider update, pulse flop
module as_cgu_divchan
    import as_pack::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             div_wr_i,
    input  logic [DIV_W-1:0] div_wdat_i,
    output logic [DIV_W-1:0] div_rd_o,
    output logic             pend_o,
    output logic             clk_en_o
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pulse_q, pulse_d;
    logic             terminal;
    logic [DIV_W-1:0] cnt_next;

    // en_i is the CTRL bit as it will be next cycle, so state_q always mirrors the current CTRL bit
    assign terminal = (state_q != ST_OFF) && (cnt_q == div_act_q);
    assign cnt_next = terminal ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pulse_d    = en_i && terminal;
        if (div_wr_i) begin
            div_pend_d = div_wdat_i;
        end
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (div_wr_i) begin
                    div_act_d = div_wdat_i;
                end
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_next;
                if (div_wr_i) begin
                    if (terminal) begin
                        div_act_d = div_wdat_i;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
                if (!en_i) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            end
            ST_PEND: begin
                cnt_d = cnt_next;
                if (terminal) begin
                    div_act_d = div_wr_i ? div_wdat_i : div_pend_q;
                    state_d   = ST_RUN;
                end
                if (!en_i) begin
                    div_act_d = div_pend_q;
                    state_d   = ST_OFF;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset lands in RUN because CTRL resets with every channel enabled
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            div_act_q  <= '0;
            div_pend_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pulse_q    <= pulse_d;
        end
    end

    assign div_rd_o = div_pend_q;
    assign pend_o   = (state_q == ST_PEND);
    assign clk_en_o = pulse_q;

endmodule

// File: rtl/as_cgu_divctrl.sv
// rtl/as_cgu_divctrl.sv - CGU register file, address decode and per-domain enable channels
module as_cgu_divctrl
    import as_pack::*;
#(
    parameter int NCH    = 4,
    parameter int DIV_W  = 16,
    parameter int ADDR_W = 4,
    parameter int DAT_W  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DAT_W-1:0]  dat_i,
    input  logic              wr_i,
    output logic [DAT_W-1:0]  dat_o,
    output logic [NCH-1:0]    clk_en_o,
    output logic              busy_o
);

    localparam int DIV_BASE = int'(CGU_DIV0);

    logic [NCH-1:0]   ctrl_q, ctrl_d;
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   div_wr;
    logic [DIV_W-1:0] div_rd [NCH];
    logic             unused_dat;

    assign unused_dat = ^dat_i[DAT_W-1:DIV_W];

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_i && (addr_i == ADDR_W'(CGU_CTRL))) begin
            ctrl_d = dat_i[NCH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q <= '1;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign div_wr[g] = wr_i && (int'(addr_i) == DIV_BASE + g);

        as_cgu_divchan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (ctrl_d[g]),
            .div_wr_i  (div_wr[g]),
            .div_wdat_i(dat_i[DIV_W-1:0]),
            .div_rd_o  (div_rd[g]),
            .pend_o    (pend[g]),
            .clk_en_o  (clk_en_o[g])
        );
    end

    always_comb begin
        dat_o = '0;
        if (addr_i == ADDR_W'(CGU_CTRL)) begin
            dat_o[NCH-1:0] = ctrl_q;
        end else if (addr_i == ADDR_W'(CGU_STAT)) begin
            dat_o[NCH-1:0] = pend;
        end
        for (int i = 0; i < NCH; i++) begin
            if (int'(addr_i) == DIV_BASE + i) begin
                dat_o[DIV_W-1:0] = div_rd[i];
            end
        end
    end

    assign busy_o = |pend;

endmodule

// File: tb/tb_as_cgu_divctrl.sv
// tb/tb_as_cgu_divctrl.sv - scoreboard bench for as_cgu_divctrl against a timing-based reference model
module tb_as_cgu_divctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  addr_i;
    logic [63:0] dat_i;
    logic        wr_i;
    logic [63:0] dat_o;
    logic [3:0]  clk_en_o;
    logic        busy_o;

    as_cgu_divctrl dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .dat_i   (dat_i),
        .wr_i    (wr_i),
        .dat_o   (dat_o),
        .clk_en_o(clk_en_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  en;
        logic        busy;
        logic [63:0] dat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model: each running channel knows the absolute cycle of its next terminal count
    int         cyc;
    logic [3:0] m_en, m_pend, m_pulse;
    int         m_div[4], m_dpend[4], m_rd[4], m_next[4];

    function automatic logic [63:0] m_read(input logic [3:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return {60'd0, m_en};
        if (ai == 1) return {60'd0, m_pend};
        if (ai >= 2 && ai <= 5) return 64'(m_rd[ai-2]);
        return 64'd0;
    endfunction

    task automatic model_reset();
        m_en = 4'hF; m_pend = 4'h0; m_pulse = 4'h0;
        for (int n = 0; n < 4; n++) begin
            m_div[n] = 0; m_dpend[n] = 0; m_rd[n] = 0; m_next[n] = 0;
        end
    endtask

    task automatic model_update(input logic w, input logic [3:0] a, input logic [63:0] d);
        logic [3:0] nxt;
        for (int n = 0; n < 4; n++) begin
            logic term, new_en, dwr;
            int   v;
            v      = int'(d[15:0]);
            term   = m_en[n] && (m_next[n] == cyc);
            new_en = (w && a == 4'd0) ? d[n] : m_en[n];
            dwr    = w && (int'(a) == n + 2);
            nxt[n] = term && new_en;
            if (dwr) m_rd[n] = v;
            if (!m_en[n]) begin
                if (dwr) m_div[n] = v;
                if (new_en) begin
                    m_en[n]   = 1'b1;
                    m_next[n] = cyc + 1 + m_div[n];
                end
            end else if (!new_en) begin
                if (m_pend[n]) m_div[n] = m_dpend[n];
                m_pend[n] = 1'b0;
                m_en[n]   = 1'b0;
            end else begin
                if (dwr && !term) begin
                    m_pend[n]  = 1'b1;
                    m_dpend[n] = v;
                end
                if (term) begin
                    if (dwr) m_div[n] = v;
                    else if (m_pend[n]) m_div[n] = m_dpend[n];
                    m_pend[n] = 1'b0;
                    m_next[n] = cyc + 1 + m_div[n];
                end
            end
        end
        m_pulse = nxt;
    endtask

    task automatic push_exp(input logic [3:0] a);
        exp_t e;
        e.en   = m_pulse;
        e.busy = |m_pend;
        e.dat  = m_read(a);
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic step(input logic w, input logic [3:0] a, input logic [63:0] d);
        wr_i = w; addr_i = a; dat_i = d;
        push_exp(a);
        model_update(w, a, d);
        cyc++;
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom});
    endtask

    task automatic apply_reset(input int hold);
        rst_i = 1'b0; wr_i = 1'b0;
        model_reset();
        for (int i = 0; i < hold; i++) begin
            addr_i = 4'($urandom_range(0, 7));
            dat_i  = {$urandom, $urandom};
            push_exp(addr_i);
            cyc++;
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;
        for (int n = 0; n < 4; n++) m_next[n] = cyc;
    endtask

    task automatic check(input string name, input int c, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("clk_en", e.cyc, 64'(clk_en_o), 64'(e.en));
            check("busy", e.cyc, 64'(busy_o), 64'(e.busy));
            check("dat_o", e.cyc, dat_o, e.dat);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  a;
        logic [63:0] d;
        int          r;
        cyc = 0;
        rst_i = 1'b0; wr_i = 1'b0; addr_i = 4'd0; dat_i = 64'd0;
        model_reset();
        @(posedge clk_i); #1;
        apply_reset(3);

        idle(4);
        step(1'b0, 4'd1, 64'd0);
        step(1'b0, 4'd0, 64'd0);
        step(1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_0003);
        idle(12);
        step(1'b1, 4'd3, 64'd9);
        idle(14);
        step(1'b1, 4'd3, 64'd2);
        idle(16);
        step(1'b1, 4'd0, 64'hE);
        idle(3);
        step(1'b1, 4'd2, 64'd5);
        step(1'b0, 4'd2, 64'd0);
        step(1'b1, 4'd0, 64'hF);
        idle(14);
        step(1'b1, 4'd5, 64'd6);
        idle(5);
        step(1'b1, 4'd5, 64'd7);
        step(1'b1, 4'd5, 64'd1);
        idle(14);
        step(1'b1, 4'd3, 64'd8);
        step(1'b1, 4'd3, 64'd9);
        step(1'b0, 4'd1, 64'd0);
        apply_reset(2);
        step(1'b0, 4'd3, 64'd0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                apply_reset(int'($urandom_range(1, 2)));
            end else if (r < 40) begin
                a = 4'($urandom_range(0, 7));
                d = {$urandom, $urandom};
                if (a >= 4'd2 && a <= 4'd5) d[15:0] = 16'($urandom_range(0, 10));
                else if (a == 4'd0 && $urandom_range(0, 2) != 0) d[3:0] = 4'hF;
                step(1'b1, a, d);
            end else begin
                step(1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom});
            end
        end
        wr_i = 1'b0;

        @(negedge clk_i); #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
